// File: rtl/led_pwm_if.sv
// Bundles the LED driver's control inputs and its PWM/status outputs.
// The master modport is the side that drives the controls; the slave modport is the driver.
interface led_pwm_if;
  logic       enable;
  logic [1:0] luminosity;
  logic [1:0] color;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic       pwm_w;
  logic       fading;
  logic       period_start;

  modport master (
    output enable, luminosity, color,
    input  pwm_r, pwm_g, pwm_b, pwm_w, fading, period_start
  );

  modport slave (
    input  enable, luminosity, color,
    output pwm_r, pwm_g, pwm_b, pwm_w, fading, period_start
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Four-channel (R,G,B,W) LED PWM driver with linear duty fades toward colour/brightness targets.
// Define GAMMA_EN for a quadratic perceptual duty curve; otherwise duty is linear in the fade level.
//   state  | meaning
//   STEADY | every channel level equals its target
//   FADE   | at least one channel is still ramping
module led_pwm_driver #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 1024,
  parameter int STEP     = 1
) (
  input logic     clk,
  input logic     reset,
  led_pwm_if.slave bus
);
  localparam int TW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] FULL      = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST  = FULL - 1'b1;
  localparam logic [PWM_BITS-1:0] STEP_V    = PWM_BITS'(STEP);
  localparam logic [TW-1:0]       TICK_LAST = TW'(FADE_DIV - 1);

  typedef enum logic {STEADY = 1'b0, FADE = 1'b1} state_t;

  state_t state, state_nxt;

  logic                     en_q;
  logic [1:0]               lum_q, col_q;
  logic [PWM_BITS-1:0]      cnt, cnt_nxt;
  logic [TW-1:0]            tick;
  logic                     tick_wrap, cnt_wrap;
  logic [3:0][PWM_BITS-1:0] base, tgt, tgt_nxt, cur, cur_nxt, lat, lat_nxt;
  logic [3:0]               pwm, pwm_nxt;
  logic                     period_start;

  // Channel index: 0=R, 1=G, 2=B, 3=W.
  function automatic logic [PWM_BITS-1:0] step_to(input logic [PWM_BITS-1:0] c,
                                                   input logic [PWM_BITS-1:0] t);
    if (t >= c) return ((t - c) <= STEP_V) ? t : c + STEP_V;
    else        return ((c - t) <= STEP_V) ? t : c - STEP_V;
  endfunction

  function automatic logic [PWM_BITS-1:0] duty(input logic [PWM_BITS-1:0] c);
`ifdef GAMMA_EN
    logic [2*PWM_BITS-1:0] p;
    p = (2*PWM_BITS)'(c) * ((2*PWM_BITS)'(c) + (2*PWM_BITS)'(1));
    return p[2*PWM_BITS-1 -: PWM_BITS];
`else
    return c;
`endif
  endfunction

  assign tick_wrap = (tick == TICK_LAST);
  assign cnt_wrap  = (cnt == CNT_LAST);
  assign cnt_nxt   = cnt_wrap ? '0 : cnt + 1'b1;

  always_comb begin
    base = '0;
    case (col_q)
      2'b00: begin base[3] = FULL; base[0] = FULL >> 1; base[1] = FULL >> 2; end
      2'b01: base[3] = FULL;
      2'b10: base[2] = FULL;
      default: begin base[0] = FULL; base[1] = FULL >> 1; end
    endcase
    for (int i = 0; i < 4; i++) begin
      tgt_nxt[i] = '0;
      if (en_q) begin
        case (lum_q)
          2'b11:   tgt_nxt[i] = base[i];
          2'b10:   tgt_nxt[i] = base[i] >> 1;
          2'b01:   tgt_nxt[i] = base[i] >> 2;
          default: tgt_nxt[i] = '0;
        endcase
      end
      cur_nxt[i] = tick_wrap ? step_to(cur[i], tgt[i]) : cur[i];
      // Latch only at the period boundary so a period never changes shape mid-way.
      lat_nxt[i] = cnt_wrap ? duty(cur[i]) : lat[i];
      pwm_nxt[i] = (cnt_nxt < lat_nxt[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STEADY:  if (cur != tgt) state_nxt = FADE;
      FADE:    if (cur == tgt) state_nxt = STEADY;
      default: state_nxt = STEADY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= STEADY;
      en_q         <= 1'b0;
      lum_q        <= '0;
      col_q        <= '0;
      cnt          <= '0;
      tick         <= '0;
      tgt          <= '0;
      cur          <= '0;
      lat          <= '0;
      pwm          <= '0;
      period_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      en_q         <= bus.enable;
      lum_q        <= bus.luminosity;
      col_q        <= bus.color;
      cnt          <= cnt_nxt;
      tick         <= tick_wrap ? '0 : tick + 1'b1;
      tgt          <= tgt_nxt;
      cur          <= cur_nxt;
      lat          <= lat_nxt;
      pwm          <= pwm_nxt;
      period_start <= cnt_wrap;
    end
  end

  assign bus.pwm_r        = pwm[0];
  assign bus.pwm_g        = pwm[1];
  assign bus.pwm_b        = pwm[2];
  assign bus.pwm_w        = pwm[3];
  assign bus.fading       = (state == FADE);
  assign bus.period_start = period_start;
endmodule
